wb_regfile: RTL and testbench

- Writeback-stage consumer of the M/W pipeline register outputs, together with the architectural register file of the 5-stage MIPS pipeline.
- Decodes IR_W, extracts and extends load data, and selects the writeback source (load data, ALU result or PC+8).
- Writes GPRs[1..31] on the clock edge and serves the D-stage through two combinational read ports with internal W→D bypass.
- Drives a writeback trace (PC, register, data) for the testbench.

---
 rtl/wb_regfile.sv | 181 ++++++++++++++++++
 tb/tb_wb_regfile.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : MIPS writeback stage and architectural register file. Decodes
//             the W-stage instruction, extends load data, selects the
//             writeback source, commits GPR writes and serves two
//             combinational read ports with a W->D bypass. Also drives a
//             registered writeback trace.
//  Revision : 1.0  initial release
// ============================================================================
module wb_regfile #(
  parameter int          NREG     = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IR_W,
  input  logic [4:0]  WriteReg_W,
  input  logic [31:0] ReadData_W,
  input  logic [31:0] ALUOut_W,
  input  logic [31:0] PC_W,
  input  logic [31:0] PC8_W,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WB_WE,
  output logic [4:0]  WB_Addr,
  output logic [31:0] WB_Data,
  output logic [31:0] WB_PC
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_LINK = 2'd2,
    CLS_ALU  = 2'd3
  } wb_class_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  wb_class_e   cls;
  logic        we;
  logic [31:0] load_data;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  logic [31:0] gpr_q [NREG];
  logic        wb_we_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;
  logic [31:0] wb_pc_q;

  assign opcode = IR_W[31:26];
  assign funct  = IR_W[5:0];

  // Classify the W-stage instruction by its writeback source
  always_comb begin
    cls = CLS_NONE;
    case (opcode)
      OP_SPECIAL: begin
        if (funct == FN_JALR)
          cls = CLS_LINK;
        else if (funct != FN_JR && funct != FN_SYSCALL)
          cls = CLS_ALU;
      end
      OP_JAL:                               cls = CLS_LINK;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:  cls = CLS_LOAD;
      6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0e, 6'h0f:           cls = CLS_ALU;
      default:                              cls = CLS_NONE;
    endcase
  end

  // Writes are suppressed during reset so the bypass also reads 0 then
  assign we = RESET_N && (cls != CLS_NONE) && (WriteReg_W != 5'd0);

  // Extract and extend the addressed byte/halfword of the loaded word
  always_comb begin
    ld_byte = ReadData_W[7:0];
    case (ALUOut_W[1:0])
      2'd0: ld_byte = ReadData_W[7:0];
      2'd1: ld_byte = ReadData_W[15:8];
      2'd2: ld_byte = ReadData_W[23:16];
      2'd3: ld_byte = ReadData_W[31:24];
      default: ld_byte = ReadData_W[7:0];
    endcase
    ld_half = ALUOut_W[1] ? ReadData_W[31:16] : ReadData_W[15:0];
    case (opcode)
      OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_data = {24'd0, ld_byte};
      OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_data = {16'd0, ld_half};
      default: load_data = ReadData_W;
    endcase
  end

  // Select the writeback data source
  always_comb begin
    case (cls)
      CLS_LOAD: wdata = load_data;
      CLS_LINK: wdata = PC8_W;
      default:  wdata = ALUOut_W;
    endcase
  end

  // Register array; entry 0 is only ever reset, so it stays zero
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (we && WriteReg_W == i[4:0]) gpr_q[i] <= wdata;
      end
    end
  end

  // Writeback trace; address/data/PC hold when nothing is written
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      wb_pc_q   <= PC_RESET;
    end else begin
      wb_we_q <= we;
      if (we) begin
        wb_addr_q <= WriteReg_W;
        wb_data_q <= wdata;
        wb_pc_q   <= PC_W;
      end
    end
  end

  // Read port 1 with same-cycle W->D bypass
  always_comb begin
    RD1 = 32'd0;
    if (A1 != 5'd0) begin
      if (we && WriteReg_W == A1) begin
        RD1 = wdata;
      end else begin
        for (int i = 1; i < NREG; i++) begin
          if (A1 == i[4:0]) RD1 = gpr_q[i];
        end
      end
    end
  end

  // Read port 2 with same-cycle W->D bypass
  always_comb begin
    RD2 = 32'd0;
    if (A2 != 5'd0) begin
      if (we && WriteReg_W == A2) begin
        RD2 = wdata;
      end else begin
        for (int i = 1; i < NREG; i++) begin
          if (A2 == i[4:0]) RD2 = gpr_q[i];
        end
      end
    end
  end

  assign WB_WE   = wb_we_q;
  assign WB_Addr = wb_addr_q;
  assign WB_Data = wb_data_q;
  assign WB_PC   = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Directed self-checking bench for wb_regfile.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_regfile;

  logic        CLK;
  logic        RESET_N;
  logic [31:0] IR_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] ReadData_W;
  logic [31:0] ALUOut_W;
  logic [31:0] PC_W;
  logic [31:0] PC8_W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        WB_WE;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic [31:0] WB_PC;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile #(.NREG(32), .PC_RESET(32'h0000_3000)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IR_W(IR_W), .WriteReg_W(WriteReg_W),
    .ReadData_W(ReadData_W), .ALUOut_W(ALUOut_W), .PC_W(PC_W), .PC8_W(PC8_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WB_WE(WB_WE),
    .WB_Addr(WB_Addr), .WB_Data(WB_Data), .WB_PC(WB_PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one W-stage instruction, let it commit, then park a nop
  task automatic commit(input logic [31:0] ir, input logic [4:0] wr,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] pc8);
    IR_W = ir; WriteReg_W = wr; ALUOut_W = alu; PC_W = pc; PC8_W = pc8;
    @(posedge CLK); #1;
    IR_W = 32'd0; WriteReg_W = 5'd0;
    #1;
  endtask

  // Load: check the bypass before the edge and the array/trace after it
  task automatic do_load(input string tag, input logic [31:0] ir, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] exp);
    IR_W = ir; WriteReg_W = wr; ALUOut_W = alu; A2 = wr;
    #1;
    check({tag, "_byp"}, RD2, exp);
    commit(ir, wr, alu, 32'h0000_3100, 32'h0000_3108);
    A1 = wr;
    #1;
    check({tag, "_rd"}, RD1, exp);
    check({tag, "_wbd"}, WB_Data, exp);
  endtask

  initial begin
    RESET_N = 1'b0;
    IR_W = 32'd0; WriteReg_W = 5'd0; ReadData_W = 32'd0; ALUOut_W = 32'd0;
    PC_W = 32'd0; PC8_W = 32'd0; A1 = 5'd0; A2 = 5'd0;
    #3;
    // In reset: a would-be write must not show through the bypass
    IR_W = 32'h3408_1234; WriteReg_W = 5'd8; ALUOut_W = 32'h0000_1234;
    A1 = 5'd8; A2 = 5'd8;
    #1;
    check("rst_byp1", RD1, 32'd0);
    check("rst_byp2", RD2, 32'd0);
    IR_W = 32'd0; WriteReg_W = 5'd0;
    @(posedge CLK); #1;
    for (int a = 0; a < 32; a++) begin
      A1 = a[4:0]; A2 = 5'(31 - a);
      #1;
      check($sformatf("rst_rd1_%0d", a), RD1, 32'd0);
      check($sformatf("rst_rd2_%0d", 31 - a), RD2, 32'd0);
    end
    check("rst_we", {31'd0, WB_WE}, 32'd0);
    check("rst_addr", {27'd0, WB_Addr}, 32'd0);
    check("rst_data", WB_Data, 32'd0);
    check("rst_pc", WB_PC, 32'h0000_3000);

    @(negedge CLK);
    RESET_N = 1'b1;

    // ori $8, 0x1234
    commit(32'h3408_1234, 5'd8, 32'h0000_1234, 32'h0000_3000, 32'h0000_3008);
    A1 = 5'd8;
    #1;
    check("ori_rd1", RD1, 32'h0000_1234);
    check("ori_we", {31'd0, WB_WE}, 32'd1);
    check("ori_addr", {27'd0, WB_Addr}, 32'd8);
    check("ori_data", WB_Data, 32'h0000_1234);
    check("ori_pc", WB_PC, 32'h0000_3000);

    // Loads
    ReadData_W = 32'h8081_F27F;
    do_load("lb0",  32'h8000_0000, 5'd10, 32'h0000_1000, 32'h0000_007F);
    do_load("lb1",  32'h8000_0000, 5'd11, 32'h0000_1001, 32'hFFFF_FFF2);
    do_load("lbu3", 32'h9000_0000, 5'd12, 32'h0000_1003, 32'h0000_0080);
    do_load("lh2",  32'h8400_0000, 5'd13, 32'h0000_1002, 32'hFFFF_8081);
    do_load("lhu0", 32'h9400_0000, 5'd14, 32'h0000_1000, 32'h0000_F27F);
    do_load("lw",   32'h8C00_0000, 5'd15, 32'h0000_1002, 32'h8081_F27F);
    do_load("lbu2", 32'h9000_0000, 5'd16, 32'h0000_1002, 32'h0000_0081);
    do_load("lhu2", 32'h9400_0000, 5'd17, 32'h0000_1002, 32'h0000_8081);

    // addu $9 bypass on both ports
    IR_W = 32'h0000_0021; WriteReg_W = 5'd9; ALUOut_W = 32'hDEAD_BEEF;
    A1 = 5'd9; A2 = 5'd9;
    #1;
    check("byp_rd1", RD1, 32'hDEAD_BEEF);
    check("byp_rd2", RD2, 32'hDEAD_BEEF);
    commit(32'h0000_0021, 5'd9, 32'hDEAD_BEEF, 32'h0000_3200, 32'h0000_3208);
    check("arr_rd1", RD1, 32'hDEAD_BEEF);
    check("arr_rd2", RD2, 32'hDEAD_BEEF);

    // ALU write aimed at $0
    A1 = 5'd0;
    commit(32'h0000_0021, 5'd0, 32'hFFFF_FFFF, 32'h0000_3204, 32'h0000_320C);
    check("r0_rd", RD1, 32'd0);
    check("r0_we", {31'd0, WB_WE}, 32'd0);
    check("r0_hold", WB_Data, 32'hDEAD_BEEF);

    // jal -> $31 = PC+8
    commit(32'h0C00_0000, 5'd31, 32'h1234_5678, 32'h0000_3008, 32'h0000_3010);
    A1 = 5'd31;
    #1;
    check("jal_rd", RD1, 32'h0000_3010);
    check("jal_addr", {27'd0, WB_Addr}, 32'd31);
    check("jal_pc", WB_PC, 32'h0000_3008);

    // jalr -> $7 = PC+8
    commit(32'h0000_0009, 5'd7, 32'h1234_5678, 32'h0000_4000, 32'h0000_4008);
    A2 = 5'd7;
    #1;
    check("jalr_rd", RD2, 32'h0000_4008);

    // lui -> I-type ALU
    commit(32'h3C06_ABCD, 5'd6, 32'hABCD_0000, 32'h0000_4004, 32'h0000_400C);
    A2 = 5'd6;
    #1;
    check("lui_rd", RD2, 32'hABCD_0000);

    // NONE class: sw, jr, syscall, beq
    A1 = 5'd5;
    commit(32'hAC00_0000, 5'd5, 32'h5555_5555, 32'h0000_5000, 32'h0000_5008);
    check("sw_rd", RD1, 32'd0);
    check("sw_we", {31'd0, WB_WE}, 32'd0);
    check("sw_hold", WB_Data, 32'hABCD_0000);
    commit(32'h0000_0008, 5'd5, 32'h5555_5555, 32'h0000_5004, 32'h0000_500C);
    check("jr_rd", RD1, 32'd0);
    check("jr_we", {31'd0, WB_WE}, 32'd0);
    check("jr_pc", WB_PC, 32'h0000_4004);
    commit(32'h0000_000C, 5'd5, 32'h5555_5555, 32'h0000_5008, 32'h0000_5010);
    check("sys_rd", RD1, 32'd0);
    commit(32'h1000_0000, 5'd5, 32'h5555_5555, 32'h0000_500C, 32'h0000_5014);
    check("beq_rd", RD1, 32'd0);

    // Earlier writes untouched
    A1 = 5'd8;
    #1;
    check("r8_keep", RD1, 32'h0000_1234);

    // Asynchronous reset between edges with a write pending
    @(negedge CLK);
    IR_W = 32'h0000_0021; WriteReg_W = 5'd20; ALUOut_W = 32'h0000_1111;
    A1 = 5'd9; A2 = 5'd20;
    #1;
    check("pre_r9", RD1, 32'hDEAD_BEEF);
    RESET_N = 1'b0;
    #1;
    check("arst_r9", RD1, 32'd0);
    check("arst_byp", RD2, 32'd0);
    check("arst_pc", WB_PC, 32'h0000_3000);
    @(posedge CLK); #1;
    check("arst_r20", RD2, 32'd0);
    check("arst_we", {31'd0, WB_WE}, 32'd0);
    IR_W = 32'd0; WriteReg_W = 5'd0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("post_r20", RD2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
